// File: rtl/reg_dump_if.sv
// Register-dump bus: read port toward the register file plus the valid/ready beat stream.
// master = dump engine, slave = register file / consumer side.
interface reg_dump_if #(
    parameter int W = 8,
    parameter int D = 3
);
    logic         start;
    logic         abort;
    logic [D-1:0] dump_read_address;
    logic [W-1:0] dump_read_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [D-1:0] out_address;
    logic         out_last;
    logic         busy;
    logic         done;

    modport master (
        input  start, abort, dump_read_data, out_ready,
        output dump_read_address, out_valid, out_data, out_address, out_last, busy, done
    );

    modport slave (
        output start, abort, dump_read_data, out_ready,
        input  dump_read_address, out_valid, out_data, out_address, out_last, busy, done
    );
endinterface

// File: rtl/reg_dump.sv
// Streams all 2**D registers as valid/ready beats; first beat 2 cycles after start, then one beat per 2 cycles.
// Backpressure: a SEND beat is held stable until out_ready; out_valid never depends on out_ready.
module reg_dump #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic       clk,
    input  logic       rst,
    reg_dump_if.master bus
);
    localparam logic [D-1:0] LAST_PTR = '1;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, FINISH} state_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic [D-1:0] address;
        logic         last;
    } beat_t;

    state_t       state, state_n;
    logic [D-1:0] ptr, ptr_n;
    beat_t        beat;
    logic         capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            beat  <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            if (capture) begin
                beat.data    <= bus.dump_read_data;
                beat.address <= ptr;
                beat.last    <= (ptr == LAST_PTR);
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = FETCH;
                    ptr_n   = '0;
                end
            end
            FETCH: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else begin
                    capture = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                // Abort wins over a coincident transfer; the beat still counts as delivered.
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (bus.out_ready) begin
                    if (ptr == LAST_PTR) begin
                        state_n = FINISH;
                    end else begin
                        ptr_n   = ptr + 1'b1;
                        state_n = FETCH;
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.dump_read_address = ptr;
    assign bus.out_valid         = (state == SEND);
    assign bus.out_data          = beat.data;
    assign bus.out_address       = beat.address;
    assign bus.out_last          = beat.last;
    assign bus.busy              = (state != IDLE);
    // An abort landing on the completion cycle suppresses the pulse for that dump.
    assign bus.done              = (state == FINISH) && !bus.abort;
endmodule
